// File: rtl/spi_master_core_pkg.sv
// Shared types and timing helpers for the SPI master shift engine.
// Holds the SPCR layout, FSM states and half-period mapping.
package spi_master_core_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [6:0] HALF_SPR0 = 7'd2;
  localparam logic [6:0] HALF_SPR1 = 7'd8;
  localparam logic [6:0] HALF_SPR2 = 7'd32;
  localparam logic [6:0] HALF_SPR3 = 7'd64;

  typedef struct packed {
    logic       spie;
    logic       spe;
    logic       dord;
    logic       dummy;
    logic       cpol;
    logic       cpha;
    logic [1:0] spr;
  } spcr_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  // Returns H-1 so the 6-bit counter can reach the 64-cycle setting.
  function automatic logic [5:0] hp_m1(
    input logic       spi2x,
    input logic [1:0] spr
  );
    logic [6:0] h;
    unique case (spr)
      2'b00:   h = HALF_SPR0;
      2'b01:   h = HALF_SPR1;
      2'b10:   h = HALF_SPR2;
      default: h = HALF_SPR3;
    endcase
    if (spi2x) h = h >> 1;
    return 6'(h - 7'd1);
  endfunction

  function automatic logic [7:0] rev8(
    input logic [7:0] v
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Register-file side bundle of the SPI master core.
// master = SPCR/SPSR/SPDR block, slave = shift engine.
interface spi_master_core_if;

  logic [7:0] spcr_i;
  logic       spi2x_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic [7:0] rd_data_o;
  logic       done_o;
  logic       busy_o;
  logic       wcol_o;

  modport master (
    output spcr_i,
    output spi2x_i,
    output wr_en_i,
    output wr_data_i,
    input  rd_data_o,
    input  done_o,
    input  busy_o,
    input  wcol_o
  );

  modport slave (
    input  spcr_i,
    input  spi2x_i,
    input  wr_en_i,
    input  wr_data_i,
    output rd_data_o,
    output done_o,
    output busy_o,
    output wcol_o
  );

endinterface

// File: rtl/spi_master_core_sck_gen.sv
// SCK edge timing: half-period counter plus 16-edge counter.
// Strobes mark the clk edge that toggles SCK.
module spi_sck_gen
  import spi_master_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [5:0] hp_m1_i,
  output logic       lead_o,
  output logic       trail_o,
  output logic       fin_o,
  output logic       last_o
);

  logic [5:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;
  logic       stb;

  always_comb begin
    cnt_d  = '0;
    edge_d = '0;
    stb    = 1'b0;
    if (run_i && !edge_q[4]) begin
      stb    = (cnt_q == hp_m1_i);
      cnt_d  = stb ? 6'd0 : cnt_q + 6'd1;
      edge_d = stb ? edge_q + 5'd1 : edge_q;
    end else if (run_i) begin
      edge_d = edge_q;
    end
  end

  assign lead_o  = stb & ~edge_q[0];
  assign trail_o = stb & edge_q[0];
  assign fin_o   = stb & (edge_q == 5'd15);
  assign last_o  = run_i & edge_q[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// Byte-wide SPI master: FSM, shifters and registered pin outputs.
// SCK timing comes from spi_sck_gen.
module spi_master_core
  import spi_master_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  spi_master_core_if.slave    bus,
  output logic                sck_o,
  output logic                mosi_o,
  input  logic                miso_i
);

  spcr_t      spcr;
  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] seq;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wcol_q, wcol_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       dord_q, dord_d;
  logic [5:0] hp_q, hp_d;
  logic       start;
  logic       lead, trail, fin, last;
  logic       unused_spcr;

  assign spcr        = spcr_t'(bus.spcr_i);
  assign unused_spcr = ^{spcr.spie, spcr.dummy};
  assign start       = bus.wr_en_i & spcr.spe;
  // Shifter always emits bit 0 first; MSB-first data is reversed on load.
  assign seq = spcr.dord ? bus.wr_data_i : rev8(bus.wr_data_i);

  spi_sck_gen u_sck_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (state_q == XFER),
    .hp_m1_i (hp_q),
    .lead_o  (lead),
    .trail_o (trail),
    .fin_o   (fin),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    wcol_d  = 1'b0;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    dord_d  = dord_q;
    hp_d    = hp_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        sck_d   = spcr.cpol;
        mosi_d  = 1'b1;
        if (start) begin
          state_d = XFER;
          cpol_d  = spcr.cpol;
          cpha_d  = spcr.cpha;
          dord_d  = spcr.dord;
          hp_d    = hp_m1(bus.spi2x_i, spcr.spr);
          rx_d    = '0;
          if (spcr.cpha) begin
            sh_d = seq;
          end else begin
            mosi_d = seq[0];
            sh_d   = {1'b0, seq[7:1]};
          end
        end
      end
      XFER: begin
        wcol_d = bus.wr_en_i;
        if (!spcr.spe) begin
          state_d = IDLE;
          sck_d   = cpol_q;
          mosi_d  = 1'b1;
        end else if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
          sck_d   = cpol_q;
          mosi_d  = 1'b1;
          rd_d    = dord_q ? rx_q : rev8(rx_q);
        end else begin
          if (lead | trail) sck_d = ~sck_q;
          if (cpha_q ? trail : lead) rx_d = {miso_i, rx_q[7:1]};
          if (cpha_q ? lead : (trail & ~fin)) begin
            mosi_d = sh_q[0];
            sh_d   = {1'b0, sh_q[7:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == XFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wcol_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      dord_q  <= 1'b0;
      hp_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wcol_q  <= wcol_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      dord_q  <= dord_d;
      hp_q    <= hp_d;
    end
  end

  assign bus.rd_data_o = rd_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = busy_q;
  assign bus.wcol_o    = wcol_q;
  assign sck_o         = sck_q;
  assign mosi_o        = mosi_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core with an SPI slave model.
// Expected bytes are queued on write and checked on done_o.
module tb_spi_master_core;
  import spi_master_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sck, mosi, miso;
  logic loop_en;

  spi_master_core_if bus ();

  spi_master_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sck_o  (sck),
    .mosi_o (mosi),
    .miso_i (miso)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int abs_cyc = 0;
  int n_done = 0;
  int n_wcol = 0;
  int done_at_prev = 0;
  int done_at_last = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  // slave model state
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic       sl_miso = 1'b1;
  logic       sl_cpol = 1'b0;
  logic       sl_cpha = 1'b0;
  logic       sl_dord = 1'b0;
  logic       sl_prev_busy = 1'b0;
  logic       sl_prev_sck = 1'b0;
  int         sl_i = 0;
  int         sl_k = 0;
  int         sl_edges = 0;
  spcr_t      cfg;

  assign cfg  = spcr_t'(bus.spcr_i);
  assign miso = loop_en ? mosi : sl_miso;

  function automatic logic sl_bit(input int i);
    return sl_dord ? sl_tx[i] : sl_tx[7-i];
  endfunction

  always @(bus.busy_o or sck) begin
    if (bus.busy_o && !sl_prev_busy) begin
      sl_cpol  = cfg.cpol;
      sl_cpha  = cfg.cpha;
      sl_dord  = cfg.dord;
      sl_i     = 0;
      sl_edges = 0;
      sl_rx    = 8'h00;
      sl_miso  = sl_cpha ? 1'b1 : sl_bit(0);
    end else if (bus.busy_o && sck != sl_prev_sck) begin
      sl_edges++;
      sl_k = sl_dord ? sl_i : 7 - sl_i;
      if (sck != sl_cpol) begin
        if (sl_cpha) begin
          if (sl_i < 8) sl_miso = sl_bit(sl_i);
        end else if (sl_i < 8) begin
          sl_rx[sl_k] = mosi;
        end
      end else begin
        if (sl_cpha) begin
          if (sl_i < 8) sl_rx[sl_k] = mosi;
          sl_i++;
        end else begin
          sl_i++;
          if (sl_i < 8) sl_miso = sl_bit(sl_i);
        end
      end
    end
    sl_prev_busy = bus.busy_o;
    sl_prev_sck  = sck;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    abs_cyc++;
    if (bus.done_o) begin
      n_done++;
      done_at_prev = done_at_last;
      done_at_last = abs_cyc;
    end
    if (bus.wcol_o) n_wcol++;
  endtask

  task automatic cfg_set(input logic [7:0] v, input logic x2);
    bus.spcr_i  = v;
    bus.spi2x_i = x2;
    tick();
  endtask

  task automatic do_write(input logic [7:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = d;
    cyc = 0;
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] tx, input logic [7:0] rx);
    exp_tx_q.push_back(tx);
    exp_rx_q.push_back(rx);
  endtask

  task automatic drop();
    if (exp_tx_q.size() > 0) void'(exp_tx_q.pop_front());
    if (exp_rx_q.size() > 0) void'(exp_rx_q.pop_front());
  endtask

  task automatic finish_xfer(input string tag, input int exp_at);
    int at;
    logic [7:0] etx, erx;
    while (!bus.done_o && cyc < exp_at + 40) tick();
    at = bus.done_o ? cyc : -1;
    check({tag, "_done_cyc"}, at, exp_at);
    etx = 8'h00;
    erx = 8'h00;
    if (exp_rx_q.size() > 0) erx = exp_rx_q.pop_front();
    if (exp_tx_q.size() > 0) etx = exp_tx_q.pop_front();
    check({tag, "_rd_data"}, int'(bus.rd_data_o), int'(erx));
    check({tag, "_mosi_byte"}, int'(sl_rx), int'(etx));
    check({tag, "_edges"}, sl_edges, 16);
    check({tag, "_busy_done"}, int'(bus.busy_o), 0);
    check({tag, "_sck_done"}, int'(sck), int'(sl_cpol));
    check({tag, "_mosi_done"}, int'(mosi), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, nb;
    rst_n         = 1'b0;
    loop_en       = 1'b0;
    bus.spcr_i    = 8'h00;
    bus.spi2x_i   = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.wr_data_i = 8'h00;
    repeat (3) tick();
    check("rst_rd", int'(bus.rd_data_o), 0);
    check("rst_sck", int'(sck), 0);
    check("rst_mosi", int'(mosi), 1);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_wcol", int'(bus.wcol_o), 0);
    rst_n = 1'b1;
    tick();

    // mode 0, H=2, loopback
    cfg_set(8'h40, 1'b0);
    loop_en = 1'b1;
    push(8'hA5, 8'hA5);
    do_write(8'hA5);
    check("m0_busy_c1", int'(bus.busy_o), 1);
    check("m0_mosi_c1", int'(mosi), 1);
    finish_xfer("m0", 34);
    tick();
    check("m0_done_pulse", int'(bus.done_o), 0);

    // mode 3, LSB first, H=32
    loop_en = 1'b0;
    sl_tx   = 8'h3C;
    cfg_set(8'h6F, 1'b1);
    tick();
    check("m3_sck_idle", int'(sck), 1);
    push(8'h96, 8'h3C);
    do_write(8'h96);
    finish_xfer("m3", 514);

    // write collision, H=8
    sl_tx = 8'h81;
    cfg_set(8'h41, 1'b0);
    d0 = n_done;
    w0 = n_wcol;
    push(8'h55, 8'h81);
    do_write(8'h55);
    repeat (20) tick();
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = 8'hAA;
    tick();
    bus.wr_en_i = 1'b0;
    check("wcol_pulse", int'(bus.wcol_o), 1);
    tick();
    check("wcol_clear", int'(bus.wcol_o), 0);
    finish_xfer("wcol", 130);
    repeat (40) tick();
    check("wcol_count", n_wcol - w0, 1);
    check("wcol_dones", n_done - d0, 1);

    // abort at edge 6
    sl_tx = 8'hF0;
    cfg_set(8'h40, 1'b0);
    d0 = n_done;
    push(8'h0F, 8'hF0);
    do_write(8'h0F);
    while (sl_edges < 6 && cyc < 100) tick();
    check("abort_reach_e6", sl_edges, 6);
    bus.spcr_i = 8'h00;
    tick();
    drop();
    check("abort_busy", int'(bus.busy_o), 0);
    check("abort_sck", int'(sck), 0);
    check("abort_mosi", int'(mosi), 1);
    repeat (60) tick();
    check("abort_no_done", n_done - d0, 0);
    check("abort_rd_kept", int'(bus.rd_data_o), 8'h81);

    // back-to-back, H=1
    loop_en = 1'b1;
    cfg_set(8'h40, 1'b1);
    d0 = n_done;
    push(8'h3C, 8'h3C);
    do_write(8'h3C);
    finish_xfer("b2b_a", 18);
    push(8'hC3, 8'hC3);
    do_write(8'hC3);
    check("b2b_busy_nogap", int'(bus.busy_o), 1);
    finish_xfer("b2b_b", 18);
    check("b2b_dones", n_done - d0, 2);
    check("b2b_gap", done_at_last - done_at_prev, 2 + 16 * 1);

    // reset mid-transfer, then write with SPE=0
    cfg_set(8'h40, 1'b0);
    push(8'h5A, 8'h5A);
    do_write(8'h5A);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    drop();
    check("mrst_rd", int'(bus.rd_data_o), 0);
    check("mrst_busy", int'(bus.busy_o), 0);
    check("mrst_sck", int'(sck), 0);
    check("mrst_mosi", int'(mosi), 1);
    check("mrst_done", int'(bus.done_o), 0);
    check("mrst_wcol", int'(bus.wcol_o), 0);
    rst_n = 1'b1;
    cfg_set(8'h00, 1'b0);
    d0 = n_done;
    do_write(8'h77);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy_o) nb++;
      tick();
    end
    check("spe0_busy", nb, 0);
    check("spe0_done", n_done - d0, 0);
    check("spe0_rd", int'(bus.rd_data_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
